multi_channel_deemphasis: RTL and testbench

Parametrised FM de-emphasis IIR low-pass, y[n] = y[n-1] + A*(x[n] - y[n-1]), for NUM_CH channels (default 2: L/R after stereo decode).
- Runtime-selectable time constant: 50 us, 75 us or bypass.
- Guard bits in the state avoid truncation limit cycles and DC error; output is rounded and saturated.
- One shared multiplier serves all channels in sequence.
- Sits between the stereo matrix and the audio output / DAC path.

---
 rtl/deemph_pkg.sv | 20 ++
 rtl/deemph_update.sv | 76 +++++++
 rtl/multi_channel_deemphasis.sv | 171 +++++++++++++++++
 tb/tb_multi_channel_deemphasis.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/deemph_pkg.sv
// rtl/deemph_pkg.sv - shared mode encodings, coefficient constants and FSM encoding for the de-emphasis block
package deemph_pkg;

    localparam logic [1:0] MODE_BYPASS = 2'd0;
    localparam logic [1:0] MODE_50US   = 2'd1;
    localparam logic [1:0] MODE_75US   = 2'd2;

    // A = (1 - exp(-1/(Fs*tau))) * 2^16
    localparam int COEF_50US_48K  = 22332;
    localparam int COEF_75US_48K  = 15895;
    localparam int COEF_50US_192K = 6483;
    localparam int COEF_75US_192K = 4397;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_OUT  = 2'd2
    } deemph_state_e;

endpackage

// File: rtl/deemph_update.sv
// rtl/deemph_update.sv - single-channel de-emphasis state update, rounding and saturation
//
// Ports:
//   x      : signed input sample (DATA_WIDTH)
//   s      : signed filter state with GUARD fractional bits (DATA_WIDTH+GUARD)
//   coef   : unsigned Q0.COEF_WIDTH filter coefficient A
//   bypass : load the state straight from the scaled input
//   s_next : updated state
//   y      : rounded, saturated output sample
module deemph_update #(
    parameter int DATA_WIDTH = 16,
    parameter int GUARD      = 8,
    parameter int COEF_WIDTH = 16
) (
    input  logic [DATA_WIDTH-1:0]       x,
    input  logic [DATA_WIDTH+GUARD-1:0] s,
    input  logic [COEF_WIDTH-1:0]       coef,
    input  logic                        bypass,
    output logic [DATA_WIDTH+GUARD-1:0] s_next,
    output logic [DATA_WIDTH-1:0]       y
);

    localparam int SW = DATA_WIDTH + GUARD;
    localparam int PW = SW + COEF_WIDTH + 2;

    localparam logic signed [PW-1:0] S_MAX = $signed({{(PW-SW+1){1'b0}}, {(SW-1){1'b1}}});
    localparam logic signed [PW-1:0] S_MIN = $signed({{(PW-SW+1){1'b1}}, {(SW-1){1'b0}}});
    localparam logic signed [SW:0]   RND   = $signed({{(SW+1-GUARD){1'b0}}, 1'b1, {(GUARD-1){1'b0}}});
    localparam logic signed [SW:0]   Y_MAX = $signed({{(GUARD+2){1'b0}}, {(DATA_WIDTH-1){1'b1}}});
    localparam logic signed [SW:0]   Y_MIN = $signed({{(GUARD+2){1'b1}}, {(DATA_WIDTH-1){1'b0}}});

    logic signed [SW-1:0]       xe;
    logic signed [SW:0]         d;
    logic signed [COEF_WIDTH:0] a_s;
    logic signed [PW-1:0]       p;
    logic signed [PW-1:0]       filt;
    logic        [SW-1:0]       s_upd;
    logic signed [SW:0]         r;
    logic signed [SW:0]         y_wide;

    assign xe   = $signed({x, {GUARD{1'b0}}});
    assign d    = $signed({xe[SW-1], xe}) - $signed({s[SW-1], s});
    assign a_s  = $signed({1'b0, coef});
    assign p    = PW'(d) * PW'(a_s);
    // Arithmetic shift floors, so a shrinking positive error can stall a few
    // LSBs below target; the GUARD bits keep that below half an output LSB.
    assign filt = PW'($signed(s)) + (p >>> COEF_WIDTH);

    // The update always lies between s and xe, so this clamp never engages
    // in practice; it keeps the state width honest.
    always_comb begin
        if (filt > S_MAX) begin
            s_upd = {1'b0, {(SW-1){1'b1}}};
        end else if (filt < S_MIN) begin
            s_upd = {1'b1, {(SW-1){1'b0}}};
        end else begin
            s_upd = filt[SW-1:0];
        end
    end

    assign s_next = bypass ? xe : s_upd;

    assign r      = $signed({s_next[SW-1], s_next}) + RND;
    assign y_wide = r >>> GUARD;

    always_comb begin
        if (y_wide > Y_MAX) begin
            y = {1'b0, {(DATA_WIDTH-1){1'b1}}};
        end else if (y_wide < Y_MIN) begin
            y = {1'b1, {(DATA_WIDTH-1){1'b0}}};
        end else begin
            y = y_wide[DATA_WIDTH-1:0];
        end
    end

endmodule

// File: rtl/multi_channel_deemphasis.sv
// rtl/multi_channel_deemphasis.sv - NUM_CH-channel FM de-emphasis IIR sharing one update datapath
//
// Ports:
//   clk       : system clock
//   reset_n   : asynchronous active-low reset
//   clear     : synchronous clear of all channel states
//   mode      : 0/3 bypass, 1 = 50 us, 2 = 75 us (sampled at accept)
//   in_data   : packed signed samples, channel k in [k*DATA_WIDTH +: DATA_WIDTH]
//   in_valid  : sample set valid
//   in_ready  : block idle and able to accept a set
//   out_data  : packed filtered samples, held between pulses
//   out_valid : one-cycle pulse when out_data carries a complete set
module multi_channel_deemphasis
    import deemph_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int NUM_CH     = 2,
    parameter int GUARD      = 8,
    parameter int COEF_WIDTH = 16,
    parameter int COEF_50    = COEF_50US_48K,
    parameter int COEF_75    = COEF_75US_48K
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         clear,
    input  logic [1:0]                   mode,
    input  logic [NUM_CH*DATA_WIDTH-1:0] in_data,
    input  logic                         in_valid,
    output logic                         in_ready,
    output logic [NUM_CH*DATA_WIDTH-1:0] out_data,
    output logic                         out_valid
);

    localparam int SW   = DATA_WIDTH + GUARD;
    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam logic [CH_W-1:0]       LAST_CH = CH_W'(NUM_CH - 1);
    localparam logic [COEF_WIDTH-1:0] A_50    = COEF_WIDTH'(COEF_50);
    localparam logic [COEF_WIDTH-1:0] A_75    = COEF_WIDTH'(COEF_75);

    deemph_state_e                state_q;
    deemph_state_e                state_d;
    logic [CH_W-1:0]              ch_q;
    logic [NUM_CH*DATA_WIDTH-1:0] x_lat_q;
    logic [NUM_CH*DATA_WIDTH-1:0] out_data_q;
    logic [1:0]                   mode_q;
    logic                         clear_pend_q;
    logic [SW-1:0]                st_q [NUM_CH];

    logic [DATA_WIDTH-1:0]        x_sel;
    logic [SW-1:0]                st_sel;
    logic [COEF_WIDTH-1:0]        coef_sel;
    logic                         bypass_sel;
    logic [SW-1:0]                s_next;
    logic [DATA_WIDTH-1:0]        y_new;

    // FSM state register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (in_valid) state_d = ST_CALC;
            ST_CALC: if (ch_q == LAST_CH) state_d = ST_OUT;
            ST_OUT:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM outputs
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state_q)
            ST_IDLE: in_ready  = 1'b1;
            ST_OUT:  out_valid = 1'b1;
            default: ;
        endcase
    end

    // Channel mux into the shared datapath; mode comes from the latched copy
    // so a change during CALC only affects the next set.
    always_comb begin
        x_sel  = x_lat_q[int'(ch_q)*DATA_WIDTH +: DATA_WIDTH];
        st_sel = st_q[ch_q];
        case (mode_q)
            MODE_50US: begin
                coef_sel   = A_50;
                bypass_sel = 1'b0;
            end
            MODE_75US: begin
                coef_sel   = A_75;
                bypass_sel = 1'b0;
            end
            default: begin
                coef_sel   = '0;
                bypass_sel = 1'b1;
            end
        endcase
    end

    deemph_update #(
        .DATA_WIDTH (DATA_WIDTH),
        .GUARD      (GUARD),
        .COEF_WIDTH (COEF_WIDTH)
    ) u_update (
        .x      (x_sel),
        .s      (st_sel),
        .coef   (coef_sel),
        .bypass (bypass_sel),
        .s_next (s_next),
        .y      (y_new)
    );

    // Datapath: latch at accept, write back one channel per CALC cycle.
    // A clear seen mid-set is deferred to the OUT edge so the set in flight
    // still uses and reports the old states.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ch_q         <= '0;
            x_lat_q      <= '0;
            mode_q       <= MODE_BYPASS;
            clear_pend_q <= 1'b0;
            out_data_q   <= '0;
            for (int k = 0; k < NUM_CH; k++) begin
                st_q[k] <= '0;
            end
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (clear) begin
                        for (int k = 0; k < NUM_CH; k++) begin
                            st_q[k] <= '0;
                        end
                    end
                    if (in_valid) begin
                        x_lat_q <= in_data;
                        mode_q  <= mode;
                        ch_q    <= '0;
                    end
                end
                ST_CALC: begin
                    st_q[ch_q] <= s_next;
                    out_data_q[int'(ch_q)*DATA_WIDTH +: DATA_WIDTH] <= y_new;
                    ch_q <= (ch_q == LAST_CH) ? '0 : ch_q + CH_W'(1);
                    if (clear) begin
                        clear_pend_q <= 1'b1;
                    end
                end
                ST_OUT: begin
                    if (clear || clear_pend_q) begin
                        for (int k = 0; k < NUM_CH; k++) begin
                            st_q[k] <= '0;
                        end
                    end
                    clear_pend_q <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign out_data = out_data_q;

endmodule

// File: tb/tb_multi_channel_deemphasis.sv
// tb/tb_multi_channel_deemphasis.sv - self-checking bench for multi_channel_deemphasis
module tb_multi_channel_deemphasis;

    localparam int DW  = 16;
    localparam int NCH = 2;

    logic              clk      = 1'b0;
    logic              reset_n  = 1'b0;
    logic              clear    = 1'b0;
    logic [1:0]        mode     = 2'd0;
    logic [NCH*DW-1:0] in_data  = '0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [NCH*DW-1:0] out_data;
    logic              out_valid;

    always #5 clk = ~clk;

    multi_channel_deemphasis #(
        .DATA_WIDTH (DW),
        .NUM_CH     (NCH)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .clear     (clear),
        .mode      (mode),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid)
    );

    typedef struct {
        int c;
        int y[NCH];
    } exp_t;

    int     n_cmp = 0;
    int     n_fail = 0;
    int     cyc = 0;
    int     dut_pulses = 0;
    longint ms[NCH];
    int     last_y[NCH];
    exp_t   eq[$];

    task automatic check(string tag, longint obs, longint expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    function automatic longint floor_div(longint a, longint b);
        longint q;
        q = a / b;
        if ((a % b) != 0 && a < 0) q = q - 1;
        return q;
    endfunction

    // Reference: y[n] = y[n-1] + A*(x - y[n-1]) on a state scaled by 256,
    // floor on the update, round-half-up and clamp on the output.
    function automatic int model_ch(int ch, int x, int m);
        longint xe;
        longint a;
        longint yv;
        xe = longint'(x) * 256;
        if (m == 1 || m == 2) begin
            a = (m == 1) ? 22332 : 15895;
            ms[ch] = ms[ch] + floor_div((xe - ms[ch]) * a, 65536);
        end else begin
            ms[ch] = xe;
        end
        yv = floor_div(ms[ch] + 128, 256);
        if (yv > 32767) yv = 32767;
        if (yv < -32768) yv = -32768;
        return int'(yv);
    endfunction

    function automatic int get_y(int k);
        logic [DW-1:0] v;
        v = out_data[k*DW +: DW];
        return int'($signed(v));
    endfunction

    task automatic tick(bit v, int x0, int x1, int m, bit clr);
        bit   rdy;
        bit   exp_v;
        exp_t e;
        logic [DW-1:0] b0;
        logic [DW-1:0] b1;
        @(negedge clk);
        cyc++;
        rdy   = (eq.size() == 0);
        exp_v = (eq.size() > 0) && (cyc - eq[0].c == NCH + 1);
        check("in_ready", in_ready, rdy);
        check("out_valid", out_valid, exp_v);
        if (out_valid) dut_pulses++;
        if (exp_v) begin
            e = eq.pop_front();
            for (int k = 0; k < NCH; k++) begin
                check($sformatf("out_data_ch%0d", k), get_y(k), e.y[k]);
                last_y[k] = get_y(k);
            end
        end
        b0 = DW'(x0);
        b1 = DW'(x1);
        in_valid = v;
        in_data  = {b1, b0};
        mode     = 2'(m);
        clear    = clr;
        if (clr) begin
            for (int k = 0; k < NCH; k++) ms[k] = 0;
        end
        if (v && rdy) begin
            e.c    = cyc;
            e.y[0] = model_ch(0, x0, m);
            e.y[1] = model_ch(1, x1, m);
            eq.push_back(e);
        end
    endtask

    task automatic send_set(int x0, int x1, int m);
        tick(1'b1, x0, x1, m, 1'b0);
        repeat (NCH + 1) tick(1'b0, x0, x1, m, 1'b0);
    endtask

    task automatic apply_reset(int n);
        @(negedge clk);
        cyc++;
        reset_n  = 1'b0;
        in_valid = 1'b0;
        clear    = 1'b0;
        eq.delete();
        for (int k = 0; k < NCH; k++) ms[k] = 0;
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        repeat (n) begin
            @(negedge clk);
            cyc++;
        end
        reset_n = 1'b1;
    endtask

    function automatic int rnd_sample();
        logic [DW-1:0] r;
        r = DW'($urandom);
        return int'($signed(r));
    endfunction

    initial begin
        int prev;
        int p0;
        for (int k = 0; k < NCH; k++) begin
            ms[k] = 0;
            last_y[k] = 0;
        end

        // Reset, then reset again in the middle of CALC
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        tick(1'b0, 0, 0, 0, 1'b0);
        check("idle_out_data", out_data, 0);
        tick(1'b1, 1234, -999, 1, 1'b0);
        tick(1'b0, 1234, -999, 1, 1'b0);
        apply_reset(2);
        tick(1'b0, 0, 0, 1, 1'b0);
        check("post_rst_in_ready", in_ready, 1);
        check("post_rst_out_data", out_data, 0);

        // Zero input from zero state
        p0 = dut_pulses;
        send_set(0, 0, 1);
        check("zero_pulse", dut_pulses - p0, 1);
        check("zero_y0", last_y[0], 0);
        check("zero_y1", last_y[1], 0);

        // Step response, 50 us
        send_set(16384, 0, 1);
        check("step_first_y0", last_y[0], 5583);
        check("step_first_y1", last_y[1], 0);
        prev = last_y[0];
        for (int i = 1; i < 60; i++) begin
            send_set(16384, 0, 1);
            check("step_monotonic", last_y[0] >= prev, 1);
            prev = last_y[0];
        end
        check("step_final_y0", last_y[0], 16384);

        // Bypass, then switch to 75 us with the same input
        send_set(-12345, 32767, 0);
        check("bypass_y0", last_y[0], -12345);
        check("bypass_y1", last_y[1], 32767);
        send_set(-12345, 32767, 2);
        check("switch_y0", last_y[0], -12345);
        check("switch_y1", last_y[1], 32767);

        // in_valid held high: one accept every NCH+2 cycles, others dropped
        p0 = dut_pulses;
        for (int i = 0; i < 20; i++) tick(1'b1, rnd_sample(), rnd_sample(), 1, 1'b0);
        repeat (NCH + 2) tick(1'b0, 0, 0, 1, 1'b0);
        check("handshake_pulses", dut_pulses - p0, 5);

        // Saturation to both rails
        for (int i = 0; i < 200; i++) send_set(32767, 32767, 1);
        check("rail_pos_y0", last_y[0], 32767);
        check("rail_pos_y1", last_y[1], 32767);
        for (int i = 0; i < 200; i++) send_set(-32768, -32768, 1);
        check("rail_neg_y0", last_y[0], -32768);
        check("rail_neg_y1", last_y[1], -32768);

        // clear during CALC: current set still filtered, next set from zero
        tick(1'b0, 0, 0, 1, 1'b1);
        tick(1'b1, 10000, 10000, 1, 1'b0);
        tick(1'b0, 0, 0, 1, 1'b1);
        tick(1'b0, 0, 0, 1, 1'b0);
        tick(1'b0, 0, 0, 1, 1'b0);
        check("clear_cur_y0", last_y[0], 3408);
        check("clear_cur_y1", last_y[1], 3408);
        send_set(0, 0, 1);
        check("clear_next_y0", last_y[0], 0);
        check("clear_next_y1", last_y[1], 0);

        // Randomised traffic: valid, data, mode and clear all random
        for (int i = 0; i < 600; i++) begin
            tick($urandom_range(0, 9) < 7, rnd_sample(), rnd_sample(),
                 int'($urandom_range(0, 3)), $urandom_range(0, 19) == 0);
        end
        repeat (NCH + 2) tick(1'b0, 0, 0, 0, 1'b0);
        check("drain_empty", eq.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
